// File: rtl/oven_pkg.sv
// Shared types and default constants for the oven bake controller.
// Optional door interlock is enabled by defining OVEN_DOOR_INTERLOCK_EN.
package oven_pkg;

    localparam int TEMP_W = 10;
    localparam int TIME_W = 10;

    localparam int unsigned AMBIENT_DEFAULT = 70;
    localparam int unsigned T_MIN_DEFAULT   = 300;
    localparam int unsigned T_MAX_DEFAULT   = 500;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREHEAT = 3'd1,
        BAKE    = 3'd2,
        DONE    = 3'd3,
        COOL    = 3'd4
    } state_t;

    function automatic logic [TEMP_W-1:0] clamp_temp(
        input logic [TEMP_W-1:0] t,
        input logic [TEMP_W-1:0] lo,
        input logic [TEMP_W-1:0] hi
    );
        if (t < lo) return lo;
        if (t > hi) return hi;
        return t;
    endfunction

endpackage

// File: rtl/oven_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module oven_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/oven_bake_controller.sv
// Bake cycle FSM with a simple oven temperature model and countdown timer.
// Define OVEN_DOOR_INTERLOCK_EN to pause heating and countdown while the door is open.
module oven_bake_controller
    import oven_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned AMBIENT   = AMBIENT_DEFAULT,
    parameter int unsigned RAMP_STEP = 5,
    parameter int unsigned COOL_STEP = 5,
    parameter int unsigned T_MIN     = T_MIN_DEFAULT,
    parameter int unsigned T_MAX     = T_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              on_off,
    input  logic              start,
    input  logic              cancel,
    input  logic [TEMP_W-1:0] temp_set,
    input  logic [TIME_W-1:0] time_set,
    input  logic              door_open,
    output logic [TEMP_W-1:0] cur_temp,
    output logic [TIME_W-1:0] time_left,
    output logic              heater_on,
    output logic              alarm,
    output state_t            state
);

    localparam logic [TEMP_W-1:0] AMB  = TEMP_W'(AMBIENT);
    localparam logic [TEMP_W-1:0] RAMP = TEMP_W'(RAMP_STEP);
    localparam logic [TEMP_W-1:0] COOLS = TEMP_W'(COOL_STEP);
    localparam logic [TEMP_W-1:0] TLO  = TEMP_W'(T_MIN);
    localparam logic [TEMP_W-1:0] THI  = TEMP_W'(T_MAX);

    logic              tick;
    logic              start_q;
    logic              start_edge;
    logic              abort;
    logic              door_hold;
    logic              start_ok;
    logic [TEMP_W-1:0] setpoint;

    state_t            state_nxt;
    logic [TEMP_W-1:0] temp_nxt;
    logic [TIME_W-1:0] time_nxt;
    logic [TEMP_W-1:0] setp_nxt;
    logic              heater_nxt;
    logic              alarm_nxt;

    oven_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Saturating moves: heating never overshoots the setpoint, cooling never undershoots ambient.
    function automatic logic [TEMP_W-1:0] heat(input logic [TEMP_W-1:0] t,
                                               input logic [TEMP_W-1:0] sp);
        if (t >= sp) return t;
        if ((sp - t) <= RAMP) return sp;
        return t + RAMP;
    endfunction

    function automatic logic [TEMP_W-1:0] cool(input logic [TEMP_W-1:0] t);
        if (t <= AMB) return t;
        if ((t - AMB) <= COOLS) return AMB;
        return t - COOLS;
    endfunction

    assign start_edge = start & ~start_q;
    assign abort      = cancel | ~on_off;

`ifdef OVEN_DOOR_INTERLOCK_EN
    assign door_hold = door_open && (state == PREHEAT || state == BAKE);
    assign start_ok  = start_edge & ~door_open;
`else
    logic unused_door;
    assign unused_door = door_open;
    assign door_hold   = 1'b0;
    assign start_ok    = start_edge;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves
    // a value unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        temp_nxt  = cur_temp;
        time_nxt  = time_left;
        setp_nxt  = setpoint;

        unique case (state)
            IDLE: begin
                if (tick) temp_nxt = cool(cur_temp);
                if (start_ok && on_off && time_set != '0) begin
                    setp_nxt  = clamp_temp(temp_set, TLO, THI);
                    time_nxt  = time_set;
                    state_nxt = PREHEAT;
                end
            end
            PREHEAT: begin
                if (tick && !door_hold) temp_nxt = heat(cur_temp, setpoint);
                if (abort) begin
                    time_nxt  = '0;
                    state_nxt = COOL;
                end else if (cur_temp >= setpoint) begin
                    state_nxt = BAKE;
                end
            end
            BAKE: begin
                if (tick && !door_hold) begin
                    temp_nxt = heat(cur_temp, setpoint);
                    if (time_left != '0) time_nxt = time_left - 1'b1;
                end
                if (abort) begin
                    time_nxt  = '0;
                    state_nxt = COOL;
                end else if (time_left == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (tick) temp_nxt = cool(cur_temp);
                if (start_edge || cancel) state_nxt = COOL;
            end
            COOL: begin
                if (tick) temp_nxt = cool(cur_temp);
                if (cur_temp == AMB) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next-state values so they line up with state.
        heater_nxt = ((state_nxt == PREHEAT) ||
                      (state_nxt == BAKE && temp_nxt < setp_nxt)) && !door_hold;
        alarm_nxt  = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_temp  <= AMB;
            time_left <= '0;
            setpoint  <= TLO;
            heater_on <= 1'b0;
            alarm     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_temp  <= temp_nxt;
            time_left <= time_nxt;
            setpoint  <= setp_nxt;
            heater_on <= heater_nxt;
            alarm     <= alarm_nxt;
            start_q   <= start;
        end
    end

endmodule
